// File: rtl/cr_kme_fifo_unpacker.sv
// Pops wide entries from the KME FIFO and replays each one as a run of
// OUT_W-bit beats, least-significant slice first, with the last beat flagged.
module cr_kme_fifo_unpacker #(
  parameter int IN_W  = 611,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ack,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [3:0]       out_beat,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int         NUM_BEATS = (IN_W + OUT_W - 1) / OUT_W;
  localparam int         PAD_W     = NUM_BEATS * OUT_W;
  localparam logic [3:0] LAST_BEAT = 4'(NUM_BEATS - 1);
  localparam logic       ONE_BEAT  = (NUM_BEATS == 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  hold, hold_nxt;
  logic [PAD_W-1:0] hold_pad, in_pad;
  logic [OUT_W-1:0] next_slice, data_nxt;
  logic [3:0]       beat_inc, beat_nxt;
  logic             valid_nxt, last_nxt, fire;
  logic [CNT_W-1:0] cnt_nxt;

  assign fire     = out_valid & out_ready;
  assign in_ack   = !rst & in_valid & ((state == IDLE) | (fire & out_last));
  assign busy     = out_valid;
  assign beat_inc = out_beat + 4'd1;

  // Zero-extend to a whole number of beats so the final slice reads 0 above IN_W.
  always_comb begin
    hold_pad             = '0;
    hold_pad[IN_W-1:0]   = hold;
    in_pad               = '0;
    in_pad[IN_W-1:0]     = in_data;
  end

  always_comb begin
    next_slice = '0;
    for (int unsigned k = 0; k < NUM_BEATS; k++) begin
      if (beat_inc == 4'(k)) next_slice = hold_pad[k*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    beat_nxt  = out_beat;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    last_nxt  = out_last;
    cnt_nxt   = word_cnt;
    if (fire && out_last && (word_cnt != '1)) cnt_nxt = word_cnt + CNT_W'(1);
    if (in_ack) begin
      hold_nxt  = in_data;
      beat_nxt  = '0;
      data_nxt  = in_pad[OUT_W-1:0];
      valid_nxt = 1'b1;
      last_nxt  = ONE_BEAT;
      state_nxt = SEND;
    end else if ((state == SEND) && fire) begin
      if (!out_last) begin
        beat_nxt = beat_inc;
        data_nxt = next_slice;
        last_nxt = (beat_inc == LAST_BEAT);
      end else begin
        // FIFO stalled at the last beat: drop back to IDLE, out_data keeps its value.
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        beat_nxt  = '0;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      out_beat  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      out_beat  <= beat_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      word_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_unpacker.sv
// Bench for cr_kme_fifo_unpacker: FIFO/beat-queue model checked every cycle,
// plus literal checks and a narrow-counter instance for saturation.
module tb_cr_kme_fifo_unpacker;

  localparam int IN_W = 611;
  localparam int NB   = 10;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [IN_W-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ack;
  logic [63:0]     out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [3:0]      out_beat;
  logic            busy;
  logic [15:0]     word_cnt;

  cr_kme_fifo_unpacker #(.IN_W(611), .OUT_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_beat(out_beat), .busy(busy), .word_cnt(word_cnt)
  );

  // Narrow instance: single-beat entries and a 4-bit counter to reach saturation quickly.
  logic        s_rst = 1'b1;
  logic [39:0] s_in_data = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ack;
  logic [63:0] s_out_data;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic        s_out_last;
  logic [3:0]  s_out_beat;
  logic        s_busy;
  logic [3:0]  s_word_cnt;

  cr_kme_fifo_unpacker #(.IN_W(40), .OUT_W(64), .CNT_W(4)) dut_s (
    .clk(clk), .rst(s_rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ack(s_in_ack),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .out_beat(s_out_beat), .busy(s_busy), .word_cnt(s_word_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  beat;
    logic        last;
  } beat_t;

  beat_t           exp_q[$];
  logic [IN_W-1:0] fifo_q[$];
  int              vectors = 0;
  int              miscompares = 0;
  logic            pop_pend = 1'b0;
  logic            armed = 1'b0;
  logic [15:0]     wcnt = '0;
  logic [63:0]     last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] rnd_entry();
    logic [639:0] w;
    for (int i = 0; i < 20; i++) w[i*32 +: 32] = $urandom;
    return w[IN_W-1:0];
  endfunction

  function automatic beat_t mk_beat(input logic [IN_W-1:0] e, input int k);
    beat_t b;
    logic [639:0] w;
    w = '0;
    w[IN_W-1:0] = e;
    w = w >> (k * 64);
    b.data = w[63:0];
    b.beat = 4'(k);
    b.last = (k == NB - 1);
    return b;
  endfunction

  // FIFO model: head presented after each edge, popped on the edge after an ack.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      fifo_q.delete(0);
      pop_pend = 1'b0;
    end
    if (fifo_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = fifo_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = rnd_entry();
    end
  end

  always @(negedge clk) begin
    logic fire_m, e_ack;
    if (rst) begin
      chk("in_ack_during_rst", in_ack, 0);
      exp_q.delete();
      wcnt = '0;
      last_data = '0;
      armed = 1'b1;
    end else if (armed) begin
      fire_m = (exp_q.size() > 0) && out_ready;
      e_ack  = in_valid && ((exp_q.size() == 0) || (fire_m && exp_q.size() == 1));
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("busy", busy, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_beat", out_beat, exp_q[0].beat);
        chk("out_last", out_last, exp_q[0].last);
        last_data = exp_q[0].data;
      end else begin
        chk("idle_out_data", out_data, last_data);
        chk("idle_out_last", out_last, 0);
        chk("idle_out_beat", out_beat, 0);
      end
      chk("in_ack", in_ack, e_ack);
      chk("word_cnt", word_cnt, wcnt);
      if (fire_m) begin
        if (exp_q[0].last && wcnt != 16'hFFFF) wcnt++;
        exp_q.delete(0);
      end
      if (e_ack)
        for (int k = 0; k < NB; k++) exp_q.push_back(mk_beat(in_data, k));
      if (in_ack) pop_pend = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_beat(input int b, input int lim);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_beat == 4'(b)) found = 1;
    end
    if (!found) chk("wait_beat_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int lim);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !out_valid) found = 1;
    end
    if (!found) chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [639:0]    w;
    logic [IN_W-1:0] pat;
    for (int k = 0; k < NB; k++) w[k*64 +: 64] = 64'h1111_1111_1111_1111 * k;
    pat = w[IN_W-1:0];

    // Reset state
    cyc(2);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_out_data", out_data, 0);

    // Empty FIFO for 20 cycles, then a single pattern entry
    cyc(20);
    fifo_q.push_back(pat);
    wait_beat(3, 40);
    chk("pat_beat3", out_data, 64'h3333_3333_3333_3333);
    wait_beat(9, 40);
    chk("pat_beat9", out_data, 64'h0000_0001_9999_9999);
    chk("pat_last9", out_last, 1);
    cyc(3);
    chk("single_word_cnt", word_cnt, 1);
    chk("single_idle", out_valid, 0);

    // Back-to-back: three entries
    for (int i = 0; i < 3; i++) fifo_q.push_back(rnd_entry());
    wait_idle(100);
    cyc(1);
    chk("b2b_word_cnt", word_cnt, 4);

    // Backpressure 1,0,0,1 with a second entry waiting
    fifo_q.push_back(rnd_entry());
    fifo_q.push_back(rnd_entry());
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc(1);
    end
    out_ready = 1'b1;
    wait_idle(100);
    cyc(1);
    chk("bp_word_cnt", word_cnt, 6);

    // Reset after beat 4 fires, FIFO still non-empty
    fifo_q.push_back(rnd_entry());
    fifo_q.push_back(rnd_entry());
    wait_beat(4, 40);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("post_rst_in_ack", in_ack, 1);
    wait_idle(60);
    cyc(1);
    chk("post_rst_word_cnt", word_cnt, 1);

    // Counter saturation on the narrow instance
    s_in_data   = 40'hA5_1234_5678;
    s_in_valid  = 1'b1;
    s_out_ready = 1'b1;
    #1;
    chk("s_in_ack_during_rst", s_in_ack, 0);
    cyc(1);
    s_rst = 1'b0;
    cyc(6);
    chk("s_word_cnt_5", s_word_cnt, 5);
    chk("s_out_data", s_out_data, 64'h0000_00A5_1234_5678);
    chk("s_out_last", s_out_last, 1);
    chk("s_out_beat", s_out_beat, 0);
    chk("s_busy", s_busy, 1);
    chk("s_in_ack", s_in_ack, 1);
    cyc(10);
    chk("s_word_cnt_sat", s_word_cnt, 15);
    cyc(1);
    chk("s_word_cnt_hold", s_word_cnt, 15);
    cyc(13);
    chk("s_word_cnt_stay", s_word_cnt, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
